// File: rtl/store_narrowing_unit_pkg.sv
// Shared types for the store narrowing unit: access-size encoding, skid-buffer
// states and the byte-enable width.
package store_narrowing_unit_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    SB   = 2'b00,
    SH   = 2'b01,
    SW   = 2'b10,
    RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } skid_e;

endpackage

// File: rtl/store_lane_mux.sv
// Combinational lane placement and byte-enable generation for one store.
// Misaligned SH/SW are placed at their natural alignment; RSVD places as SW.
module store_lane_mux
  import store_narrowing_unit_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] data,
  input  size_e             size,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata,
  output logic              illegal
);

  always_comb begin
    be      = '1;
    wdata   = data;
    illegal = 1'b0;
    unique case (size)
      SB: begin
        be    = BE_W'(1) << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SH: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{data[15:0]}};
        illegal = addr_lo[0];
      end
      SW: illegal = (addr_lo != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_narrowing_unit.sv
// Store narrowing unit: converts SB/SH/SW requests into word-aligned write
// beats through a 2-entry skid buffer. STORE_MISALIGN_TRAP_EN rejects illegal
// requests with a misalign pulse instead of forcing them to natural alignment.
module store_narrowing_unit
  import store_narrowing_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_addr,
  output logic [31:0]       out_data,
  output logic [BE_W-1:0]   out_be,
  output logic              misalign,
  output logic [15:0]       store_count
);

  logic [BE_W-1:0]   mux_be;
  logic [DATA_W-1:0] mux_data;
  logic [31:0]       new_addr;
  logic              accept, retire, enq;
  skid_e             state, state_nxt;
  logic [31:0]       tail_addr, tail_data;
  logic [BE_W-1:0]   tail_be;

`ifdef STORE_MISALIGN_TRAP_EN
  logic mux_illegal;
`else
  logic illegal_unused;
`endif

  store_lane_mux u_lane (
    .addr_lo (in_addr[1:0]),
    .data    (in_data),
    .size    (size_e'(in_size)),
    .be      (mux_be),
    .wdata   (mux_data),
`ifdef STORE_MISALIGN_TRAP_EN
    .illegal (mux_illegal)
`else
    .illegal (illegal_unused)
`endif
  );

  assign new_addr  = {in_addr[31:2], 2'b00};
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

`ifdef STORE_MISALIGN_TRAP_EN
  assign enq = accept & ~mux_illegal;

  always_ff @(posedge clk) begin
    if (reset) misalign <= 1'b0;
    else       misalign <= accept & mux_illegal;
  end
`else
  assign enq      = accept;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (enq) state_nxt = ONE;
      ONE: begin
        if (enq && !retire)      state_nxt = TWO;
        else if (!enq && retire) state_nxt = EMPTY;
      end
      TWO:     if (retire) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Head entry drives out_* directly; it is cleared on reset so the
  // outputs read zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_addr <= '0;
      out_data <= '0;
      out_be   <= '0;
    end else if ((state == EMPTY && enq) || (state == ONE && enq && retire)) begin
      out_addr <= new_addr;
      out_data <= mux_data;
      out_be   <= mux_be;
    end else if (state == TWO && retire) begin
      out_addr <= tail_addr;
      out_data <= tail_data;
      out_be   <= tail_be;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ONE && enq && !retire) begin
      tail_addr <= new_addr;
      tail_data <= mux_data;
      tail_be   <= mux_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       store_count <= '0;
    else if (retire) store_count <= store_count + 16'd1;
  end

endmodule

// File: doc/store_narrowing_unit.md
STORE_NARROWING_UNIT -- requirements
Module: store_narrowing_unit

Interface
REQ-001 The module SHALL expose the following ports, clock and reset first:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  store request present.
- in_ready  output  1  unit can accept a request this cycle.
- in_addr  input  32  byte address of the store.
- in_data  input  32  register value to store; byte in [7:0], halfword in [15:0].
- in_size  input  2  00 = SB, 01 = SH, 10 = SW, 11 = reserved.
- out_valid  output  1  memory write beat present.
- out_ready  input  1  memory accepts the beat.
- out_addr  output  32  word-aligned address, in_addr with bits [1:0] cleared.
- out_data  output  32  lane-placed write data.
- out_be  output  4  byte enables; bit i qualifies out_data[8i+7:8i].
- misalign  output  1  one-cycle pulse when a request is rejected.
- store_count  output  16  number of beats accepted by memory.

Function
REQ-002 A request SHALL be accepted on a cycle where in_valid and in_ready are both 1. A beat SHALL be retired on a cycle where out_valid and out_ready are both 1.
REQ-003 Narrowing SHALL operate as follows, with a = in_addr[1:0]:
- SB: out_be = 1 << a; in_data[7:0] replicated into all four lanes.
- SH: out_be = 0011 when a = 0, 1100 when a = 2; in_data[15:0] replicated into both halves.
- SW: out_be = 1111; out_data = in_data.
REQ-004 A request SHALL be classed as illegal when it is SH with a[0] = 1, SW with a != 0, or in_size = 11.
REQ-005 Buffering SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO.
- in_ready = 1 in EMPTY and ONE, 0 in TWO.
- out_valid = 1 in ONE and TWO.
- out_* SHALL always present the oldest entry.
REQ-006 State transitions SHALL be:
- EMPTY to ONE on a legal accept.
- ONE to TWO on a legal accept with no retire.
- ONE to EMPTY on a retire with no accept.
- ONE stays ONE on a simultaneous legal accept and retire.
- TWO to ONE on a retire.
- An illegal accept never enqueues.
REQ-007 Latency SHALL be one cycle: a request accepted in cycle N appears on out_* in cycle N+1 when the buffer was EMPTY. Ordering SHALL be strictly FIFO.
REQ-008 Combinational paths: in_ready SHALL depend only on registered state, with no path from out_ready. out_* SHALL be driven from registers.
REQ-009 store_count SHALL increment by 1 per retired beat and wrap from 0xFFFF to 0x0000.

Reset
REQ-010 While reset = 1 at a clock edge, the unit SHALL enter EMPTY and drive the following values:
- out_valid = 0 and in_ready = 1 on the following cycle.
- out_addr = 0, out_data = 0, out_be = 0.
- misalign = 0, store_count = 0.
REQ-011 Reset SHALL take priority over a simultaneous accept or retire, and all buffered entries SHALL be discarded. A beat offered on the cycle reset is asserted SHALL be treated as not retired and SHALL not be counted.

Configuration
REQ-012 Macro STORE_MISALIGN_TRAP_EN SHALL select the handling of illegal requests.
- Defined: an illegal request is consumed (in_ready handshake completes) but not enqueued, and misalign pulses high for exactly the cycle after acceptance.
- Undefined: misalign is tied to 0; a misaligned SH/SW has its address forced down to natural alignment (a[0] cleared for SH, a cleared to 0 for SW) and is enqueued as legal; in_size = 11 is treated as SW.

Structure
REQ-013 A shared package SHALL hold:
- the size encoding enum (SB, SH, SW, RSVD);
- the skid-state enum (EMPTY, ONE, TWO);
- the byte-enable width constant.
REQ-014 The lane placement and byte-enable logic SHALL be one combinational sub-module, store_lane_mux, instantiated once.

Verification
REQ-015 The bench SHALL cover the following directed scenarios:
- SB: addr 0x1003, data 0x000000AB -> out_be 1000, out_data 0xABABABAB, out_addr 0x1000, one cycle later.
- SH: addr 0x2002, data 0x0000BEEF -> out_be 1100, out_data 0xBEEFBEEF.
- Backpressure: out_ready = 0 with three back-to-back SW requests -> third stalled (in_ready = 0 in TWO); on release, beats retire in order and store_count = 3.
- With STORE_MISALIGN_TRAP_EN defined: SW to 0x3001 -> no out_valid, misalign = 1 for one cycle. Without the macro: out_addr 0x3000, out_be 1111.
- Reset asserted in TWO -> next cycle out_valid = 0, in_ready = 1, store_count = 0.
- Wrap: preload 0xFFFF retirements, retire one more -> store_count = 0x0000.
